// File: rtl/hdlc_pkg.sv
// HDLC receive deframer shared definitions.
// Default geometry and the line-event codes of the run classifier.
package hdlc_pkg;

  localparam int DEF_STUFF_RUN = 5;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_CNT_W     = 8;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_DATA,
    EV_STUFF,
    EV_FLAG,
    EV_ABORT
  } line_ev_t;

endpackage

// File: rtl/hdlc_bit_delay.sv
// Fixed-depth bit delay line with per-slot valid tracking.
// A flush empties the line so flag bits never reach the payload.
module hdlc_bit_delay #(
  parameter int DEPTH = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic shift,
  input  logic flush,
  input  logic din,
  output logic dout,
  output logic dout_valid
);

  logic [DEPTH-1:0] bits;
  logic [DEPTH-1:0] vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bits <= '0;
      vld  <= '0;
    end else if (flush) begin
      bits <= '0;
      vld  <= '0;
    end else if (shift) begin
      bits <= {bits[DEPTH-2:0], din};
      vld  <= {vld[DEPTH-2:0], 1'b1};
    end
  end

  assign dout       = bits[DEPTH-1];
  assign dout_valid = vld[DEPTH-1];

endmodule

// File: rtl/hdlc_deframer.sv
// HDLC receive deframer: flag/stuff/abort detection,
// destuffing, LSB-first word assembly and frame signalling.
module hdlc_deframer
  import hdlc_pkg::*;
#(
  parameter int STUFF_RUN = DEF_STUFF_RUN,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  input  logic              in_en,
  output logic              disc,
  output logic              flag,
  output logic              err,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              in_frame,
  output logic              frame_end,
  output logic              frame_abort,
  output logic [CNT_W-1:0]  err_count
);

  localparam int RW = $clog2(STUFF_RUN + 3);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [RW-1:0] R_STUFF = RW'(STUFF_RUN);
  localparam logic [RW-1:0] R_FLAG  = RW'(STUFF_RUN + 1);
  localparam logic [RW-1:0] R_MAX   = RW'(STUFF_RUN + 2);
  localparam logic [BW-1:0] B_LAST  = BW'(DATA_W - 1);

  logic [RW-1:0]     run;
  logic [BW-1:0]     bcnt;
  logic [DATA_W-1:0] sreg;
  logic              got_word;

  line_ev_t          ev;
  logic              dl_bit;
  logic              dl_vld;
  logic              shift;
  logic              flush;
  logic              commit;
  logic [DATA_W-1:0] word_next;

  always_comb begin
    ev = EV_NONE;
    if (in_en) begin
      if (in) begin
        ev = (run == R_FLAG) ? EV_ABORT : EV_DATA;
      end else begin
        unique case (1'b1)
          run == R_STUFF: ev = EV_STUFF;
          run == R_FLAG:  ev = EV_FLAG;
          default:        ev = EV_DATA;
        endcase
      end
    end
  end

  assign shift     = (ev == EV_DATA);
  assign flush     = (ev == EV_FLAG) || (ev == EV_ABORT);
  assign commit    = shift && dl_vld && in_frame;
  assign word_next = {dl_bit, sreg[DATA_W-1:1]};

  hdlc_bit_delay #(
    .DEPTH(STUFF_RUN + 2)
  ) u_delay (
    .clk        (clk),
    .reset      (reset),
    .shift      (shift),
    .flush      (flush),
    .din        (in),
    .dout       (dl_bit),
    .dout_valid (dl_vld)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run         <= '0;
      bcnt        <= '0;
      sreg        <= '0;
      got_word    <= 1'b0;
      disc        <= 1'b0;
      flag        <= 1'b0;
      err         <= 1'b0;
      data        <= '0;
      data_valid  <= 1'b0;
      in_frame    <= 1'b0;
      frame_end   <= 1'b0;
      frame_abort <= 1'b0;
      err_count   <= '0;
    end else begin
      disc        <= 1'b0;
      flag        <= 1'b0;
      err         <= 1'b0;
      data_valid  <= 1'b0;
      frame_end   <= 1'b0;
      frame_abort <= 1'b0;
      if (in_en) begin
        if (in) begin
          run <= (run == R_MAX) ? run : run + 1'b1;
        end else begin
          run <= '0;
        end
      end
      case (ev)
        EV_DATA: begin
          if (commit) begin
            sreg <= word_next;
            if (bcnt == B_LAST) begin
              data       <= word_next;
              data_valid <= 1'b1;
              bcnt       <= '0;
              got_word   <= 1'b1;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        EV_STUFF: disc <= 1'b1;
        EV_FLAG: begin
          flag <= 1'b1;
          // Counters are zero outside a frame, so idle fill falls through.
          if (bcnt != '0) begin
            frame_abort <= 1'b1;
          end else if (got_word) begin
            frame_end <= 1'b1;
          end
          in_frame <= 1'b1;
          bcnt     <= '0;
          got_word <= 1'b0;
        end
        EV_ABORT: begin
          err         <= 1'b1;
          frame_abort <= in_frame;
          in_frame    <= 1'b0;
          bcnt        <= '0;
          got_word    <= 1'b0;
          if (err_count != '1) begin
            err_count <= err_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hdlc_deframer.sv
// Scoreboard bench for hdlc_deframer with default geometry.
// Stimulus queues expected pulse records; a monitor checks them.
module tb_hdlc_deframer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in = 1'b0;
  logic       in_en = 1'b0;
  logic       disc, flag, err;
  logic [7:0] data;
  logic       data_valid, in_frame, frame_end, frame_abort;
  logic [7:0] err_count;

  hdlc_deframer dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .in_en       (in_en),
    .disc        (disc),
    .flag        (flag),
    .err         (err),
    .data        (data),
    .data_valid  (data_valid),
    .in_frame    (in_frame),
    .frame_end   (frame_end),
    .frame_abort (frame_abort),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] M_DISC = 6'b100000;
  localparam logic [5:0] M_FLAG = 6'b010000;
  localparam logic [5:0] M_ERR  = 6'b001000;
  localparam logic [5:0] M_DV   = 6'b000100;
  localparam logic [5:0] M_FE   = 6'b000010;
  localparam logic [5:0] M_FA   = 6'b000001;

  typedef struct {
    int         cyc_n;
    logic [5:0] m;
    logic [7:0] d;
    logic       fi;
    logic [7:0] ec;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic toggle = 1'b0;
  logic [7:0] e_data = 8'h00;
  logic       e_if = 1'b0;
  logic [7:0] e_ec = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tx(input logic b, input logic [5:0] m);
    exp_t e;
    @(negedge clk);
    in    = b;
    in_en = 1'b1;
    if (m != 6'b0) begin
      e.cyc_n = cyc + 1;
      e.m     = m;
      e.d     = e_data;
      e.fi    = e_if;
      e.ec    = e_ec;
      q.push_back(e);
    end
    if (toggle) begin
      @(negedge clk);
      in_en = 1'b0;
    end
  endtask

  task automatic flag_seq(input logic [5:0] m6, input logic [5:0] m0);
    tx(1'b0, 6'b0);
    for (int i = 0; i < 5; i++) tx(1'b1, 6'b0);
    tx(1'b1, m6);
    tx(1'b0, m0);
  endtask

  task automatic byte_tx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) tx(v[i], 6'b0);
  endtask

  task automatic check_quiet(input string nm);
    logic [5:0] p;
    p = {disc, flag, err, data_valid, frame_end, frame_abort};
    n_cmp++;
    if (p != 6'b0 || data != 8'h00 || in_frame || err_count != 8'h00) begin
      n_bad++;
      $display("FAIL %s: pulses=%b data=%h in_frame=%b err_count=%0d, required all zero",
               nm, p, data, in_frame, err_count);
    end
  endtask

  initial begin : monitor
    exp_t       e;
    logic [5:0] p;
    forever begin
      @(negedge clk);
      p = {disc, flag, err, data_valid, frame_end, frame_abort};
      if (!reset && p != 6'b0) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse: edge %0d pulses=%b, required none",
                   cyc, p);
        end else begin
          e = q.pop_front();
          if (e.cyc_n != cyc || e.m != p || e.d != data ||
              e.fi != in_frame || e.ec != err_count) begin
            n_bad++;
            $display("FAIL event: got edge %0d pulses=%b data=%h if=%b ec=%0d, required edge %0d pulses=%b data=%h if=%b ec=%0d",
                     cyc, p, data, in_frame, err_count,
                     e.cyc_n, e.m, e.d, e.fi, e.ec);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    @(negedge clk);
    check_quiet("reset_held");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_quiet("reset_released");

    e_if = 1'b1;
    flag_seq(6'b0, M_FLAG);

    byte_tx(8'hA5);
    e_data = 8'hA5;
    flag_seq(M_DV, M_FLAG | M_FE);

    for (int i = 0; i < 5; i++) tx(1'b1, 6'b0);
    tx(1'b0, M_DISC);
    for (int i = 0; i < 3; i++) tx(1'b1, 6'b0);
    e_data = 8'hFF;
    flag_seq(M_DV, M_FLAG | M_FE);

    // 0xA5 ends in a 1, so the err lands on the sixth appended 1.
    byte_tx(8'hA5);
    for (int i = 0; i < 5; i++) tx(1'b1, 6'b0);
    e_if = 1'b0;
    e_ec = 8'd1;
    tx(1'b1, M_ERR | M_FA);
    tx(1'b1, 6'b0);
    tx(1'b0, 6'b0);

    e_if = 1'b1;
    flag_seq(6'b0, M_FLAG);
    tx(1'b1, 6'b0);
    tx(1'b0, 6'b0);
    tx(1'b1, 6'b0);
    flag_seq(6'b0, M_FLAG | M_FA);

    toggle = 1'b1;
    byte_tx(8'hA5);
    e_data = 8'hA5;
    flag_seq(M_DV, M_FLAG | M_FE);
    toggle = 1'b0;

    tx(1'b1, 6'b0);
    tx(1'b0, 6'b0);
    tx(1'b1, 6'b0);
    tx(1'b1, 6'b0);
    @(negedge clk);
    in_en = 1'b0;
    reset = 1'b1;
    #1;
    check_quiet("reset_mid_frame");
    @(posedge clk);
    #2;
    reset = 1'b0;

    e_data = 8'h00;
    e_ec   = 8'd0;
    e_if   = 1'b1;
    flag_seq(6'b0, M_FLAG);
    byte_tx(8'h3C);
    e_data = 8'h3C;
    flag_seq(M_DV, M_FLAG | M_FE);
    @(negedge clk);
    in_en = 1'b0;
    repeat (4) @(negedge clk);

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected events outstanding, required 0",
               q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
